// File: rtl/eesic_pkg.sv
// Shared EVM front-end definitions: opcode constants, fetch FSM states, word width.
package eesic_pkg;

    localparam int unsigned WORD_W = 256;

    localparam logic [7:0] OP_STOP   = 8'h00;
    localparam logic [7:0] OP_PUSH0  = 8'h5F;
    localparam logic [7:0] OP_PUSH1  = 8'h60;
    localparam logic [7:0] OP_PUSH32 = 8'h7F;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_OP_RSP,
        FS_IMM,
        FS_VALID
    } fetch_state_e;

endpackage

// File: rtl/push_len_decode.sv
// Opcode -> PUSH classification and immediate byte count (PUSH0 is a push with zero bytes).
module push_len_decode
    import eesic_pkg::*;
(
    input  logic [7:0] i_opcode,
    output logic       o_is_push,
    output logic [5:0] o_n
);

    always_comb begin
        o_is_push = (i_opcode >= OP_PUSH0) && (i_opcode <= OP_PUSH32);
        o_n       = 6'd0;
        if ((i_opcode >= OP_PUSH1) && (i_opcode <= OP_PUSH32))
            o_n = 6'(i_opcode - OP_PUSH0);
    end

endmodule

// File: rtl/code_fetch.sv
// EVM instruction fetch: reads opcode plus PUSH immediate from byte-wide code memory
// and presents one decoded instruction per handshake to the execution core.
module code_fetch
    import eesic_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] code_len,
    input  logic              pc_req,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [7:0]        opcode,
    output logic [DATA_W-1:0] code_data,
    output logic [ADDR_W-1:0] insn_pc,
    output logic [5:0]        insn_len
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned SUM_W = ADDR_W + 1;

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_tag;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_k;
    logic [7:0]        r_opcode;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_len;
    logic              r_valid;
    logic              r_ready;

    logic [7:0]        w_byte;
    logic              w_is_push;
    logic [CNT_W-1:0]  w_n;
    logic              w_has_imm;
    logic              w_issue;
    logic [ADDR_W-1:0] w_base;
    logic [CNT_W-1:0]  w_off;
    logic [SUM_W-1:0]  w_sum;
    logic              w_in_range;

    // Slot tag says whether this cycle's byte was really read; unread slots are zero (STOP).
    assign w_byte = r_tag ? mem_rdata : OP_STOP;

    push_len_decode u_push_len_decode (
        .i_opcode  (w_byte),
        .o_is_push (w_is_push),
        .o_n       (w_n)
    );

    assign w_has_imm = w_is_push && (w_n != '0);

    // Read-issue selection: opcode read in IDLE, first immediate in OP_RSP, the rest pipelined in IMM.
    always_comb begin
        w_issue = 1'b0;
        w_base  = r_pc;
        w_off   = '0;
        case (r_state)
            FS_IDLE: begin
                w_issue = pc_req;
                w_base  = pc_i;
            end
            FS_OP_RSP: begin
                w_issue = w_has_imm;
                w_off   = CNT_W'(1);
            end
            FS_IMM: begin
                w_issue = (r_cnt > CNT_W'(1));
                w_off   = r_k;
            end
            default: ;
        endcase
        if (flush)
            w_issue = 1'b0;
    end

    // 17-bit sum so addresses wrapping past the top of memory fall out of range.
    assign w_sum      = SUM_W'(w_base) + SUM_W'(w_off);
    assign w_in_range = w_sum < SUM_W'(code_len);

    assign mem_rd_en = w_issue && w_in_range;
    assign mem_addr  = mem_rd_en ? w_sum[ADDR_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FS_IDLE;
            r_pc     <= '0;
            r_tag    <= 1'b0;
            r_cnt    <= '0;
            r_k      <= '0;
            r_opcode <= '0;
            r_data   <= '0;
            r_len    <= '0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_tag <= mem_rd_en;
            if (flush) begin
                r_state <= FS_IDLE;
                r_valid <= 1'b0;
                r_ready <= 1'b1;
            end else begin
                case (r_state)
                    FS_IDLE: begin
                        if (pc_req) begin
                            r_pc    <= pc_i;
                            r_data  <= '0;
                            r_ready <= 1'b0;
                            r_state <= FS_OP_RSP;
                        end
                    end
                    FS_OP_RSP: begin
                        r_opcode <= w_byte;
                        r_len    <= CNT_W'(w_n + CNT_W'(1));
                        if (w_has_imm) begin
                            r_cnt   <= w_n;
                            r_k     <= CNT_W'(2);
                            r_state <= FS_IMM;
                        end else begin
                            r_valid <= 1'b1;
                            r_state <= FS_VALID;
                        end
                    end
                    FS_IMM: begin
                        r_data <= {r_data[DATA_W-9:0], w_byte};
                        r_k    <= r_k + CNT_W'(1);
                        r_cnt  <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_valid <= 1'b1;
                            r_state <= FS_VALID;
                        end
                    end
                    FS_VALID: begin
                        if (insn_ready) begin
                            r_valid <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= FS_IDLE;
                        end
                    end
                    default: r_state <= FS_IDLE;
                endcase
            end
        end
    end

    assign pc_ready   = r_ready;
    assign insn_valid = r_valid;
    assign opcode     = r_opcode;
    assign code_data  = r_data;
    assign insn_pc    = r_pc;
    assign insn_len   = r_len;

endmodule

// File: tb/tb_code_fetch.sv
// Directed bench for code_fetch: table of fetch vectors plus ready-stall, flush and reset sequences.
module tb_code_fetch;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [15:0]  code_len;
    logic         pc_req;
    logic [15:0]  pc_i;
    logic         pc_ready;
    logic         mem_rd_en;
    logic [15:0]  mem_addr;
    logic [7:0]   mem_rdata;
    logic         insn_valid;
    logic         insn_ready;
    logic [7:0]   opcode;
    logic [255:0] code_data;
    logic [15:0]  insn_pc;
    logic [5:0]   insn_len;

    code_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .code_len   (code_len),
        .pc_req     (pc_req),
        .pc_i       (pc_i),
        .pc_ready   (pc_ready),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .insn_valid (insn_valid),
        .insn_ready (insn_ready),
        .opcode     (opcode),
        .code_data  (code_data),
        .insn_pc    (insn_pc),
        .insn_len   (insn_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Code memory model: one-cycle read latency, junk on the bus when no read was issued.
    logic [7:0] mem [0:65535];
    int         rd_cnt;
    int         addr_bad;
    int         bound_bad;
    logic [15:0] rd_base;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
            if (mem_addr != 16'(rd_base + 16'(rd_cnt))) addr_bad = addr_bad + 1;
            if (mem_addr >= code_len) bound_bad = bound_bad + 1;
            rd_cnt = rd_cnt + 1;
        end else begin
            mem_rdata <= 8'hEE;
        end
    end

    int tests;
    int fails;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one request at a negedge and wait (bounded) for insn_valid; lat counts clock edges.
    task automatic do_fetch(input logic [15:0] pc, input logic [15:0] clen, output int lat);
        code_len = clen;
        pc_i     = pc;
        pc_req   = 1'b1;
        rd_cnt   = 0;
        rd_base  = pc;
        lat      = 0;
        do begin
            @(posedge clk);
            lat = lat + 1;
            @(negedge clk);
            pc_req = 1'b0;
        end while (!insn_valid && lat < 100);
    endtask

    typedef struct {
        logic [15:0]  pc;
        logic [15:0]  clen;
        logic [7:0]   op;
        logic [255:0] data;
        logic [5:0]   len;
        int           lat;
        int           reads;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int           lat;
        logic [255:0] p32;
        int           vcnt;

        rst_n = 1'b0; flush = 1'b0; code_len = '0; pc_req = 1'b0; pc_i = '0;
        insn_ready = 1'b1; tests = 0; fails = 0; rd_cnt = 0; addr_bad = 0; bound_bad = 0;
        rd_base = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[0] = 8'h01;
        mem[2] = 8'h5F;
        mem[3] = 8'h80;
        mem[4] = 8'h60; mem[5] = 8'hAB;
        mem[8] = 8'h7F;
        for (int i = 1; i <= 32; i++) mem[8 + i] = 8'(i);
        mem[60] = 8'h62; mem[61] = 8'h11; mem[62] = 8'h22; mem[63] = 8'h33;
        mem[70] = 8'h63; mem[71] = 8'hAA; mem[72] = 8'hBB; mem[73] = 8'hCC; mem[74] = 8'hDD;
        mem[16'hFFFE] = 8'h61; mem[16'hFFFF] = 8'h99;

        p32 = '0;
        for (int i = 1; i <= 32; i++) p32 = (p32 << 8) | 256'(i);

        vecs[0] = '{16'd0,     16'd10,    8'h01, 256'h0,        6'd1,  2,  1};
        vecs[1] = '{16'd4,     16'd10,    8'h60, 256'hAB,       6'd2,  3,  2};
        vecs[2] = '{16'd8,     16'd100,   8'h7F, p32,           6'd33, 34, 33};
        vecs[3] = '{16'd60,    16'd63,    8'h62, 256'h112200,   6'd4,  5,  3};
        vecs[4] = '{16'd63,    16'd63,    8'h00, 256'h0,        6'd1,  2,  0};
        vecs[5] = '{16'd2,     16'd10,    8'h5F, 256'h0,        6'd1,  2,  1};
        vecs[6] = '{16'd3,     16'd10,    8'h80, 256'h0,        6'd1,  2,  1};
        vecs[7] = '{16'hFFFE,  16'hFFFF,  8'h61, 256'h0,        6'd3,  4,  1};
        vecs[8] = '{16'd70,    16'd73,    8'h63, 256'hAABB0000, 6'd5,  6,  3};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_insn_valid", 256'(insn_valid), 256'(0));
        check("rst_mem_rd_en",  256'(mem_rd_en),  256'(0));
        check("rst_opcode",     256'(opcode),     256'(0));
        check("rst_code_data",  code_data,        256'(0));
        check("rst_insn_len",   256'(insn_len),   256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_pc_ready",   256'(pc_ready),   256'(1));

        // Table-driven fetches
        foreach (vecs[v]) begin
            do_fetch(vecs[v].pc, vecs[v].clen, lat);
            check($sformatf("v%0d_latency", v),  256'(lat),        256'(vecs[v].lat));
            check($sformatf("v%0d_opcode", v),   256'(opcode),     256'(vecs[v].op));
            check($sformatf("v%0d_code_data", v), code_data,       vecs[v].data);
            check($sformatf("v%0d_insn_len", v), 256'(insn_len),   256'(vecs[v].len));
            check($sformatf("v%0d_insn_pc", v),  256'(insn_pc),    256'(vecs[v].pc));
            check($sformatf("v%0d_reads", v),    256'(rd_cnt),     256'(vecs[v].reads));
            @(negedge clk);
            check($sformatf("v%0d_ready_back", v), 256'(pc_ready),   256'(1));
            check($sformatf("v%0d_valid_drop", v), 256'(insn_valid), 256'(0));
        end
        check("read_addr_sequence", 256'(addr_bad),  256'(0));
        check("read_bound",         256'(bound_bad), 256'(0));

        // Consumer stall: outputs hold, busy requests ignored
        insn_ready = 1'b0;
        do_fetch(16'd4, 16'd10, lat);
        check("stall_latency", 256'(lat), 256'(3));
        pc_req = 1'b1; pc_i = 16'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid",    256'(insn_valid), 256'(1));
            check("stall_pc_ready", 256'(pc_ready),   256'(0));
            check("stall_opcode",   256'(opcode),     256'(8'h60));
            check("stall_data",     code_data,        256'(8'hAB));
            check("stall_len",      256'(insn_len),   256'(2));
            check("stall_pc",       256'(insn_pc),    256'(4));
        end
        pc_req = 1'b0;
        insn_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 256'(insn_valid), 256'(0));
        check("stall_release_ready", 256'(pc_ready),   256'(1));
        vcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (insn_valid) vcnt++;
        end
        check("stall_ignored_req_valid", 256'(vcnt),   256'(0));
        check("stall_ignored_req_reads", 256'(rd_cnt), 256'(2));

        // Flush while assembling a PUSH32 immediate
        code_len = 16'd100; pc_i = 16'd8; pc_req = 1'b1; rd_cnt = 0; rd_base = 16'd8;
        @(posedge clk);
        @(negedge clk);
        pc_req = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_rd_en", 256'(mem_rd_en), 256'(0));
        @(negedge clk);
        flush = 1'b0;
        check("flush_valid",    256'(insn_valid), 256'(0));
        check("flush_pc_ready", 256'(pc_ready),   256'(1));
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (insn_valid) vcnt++;
        end
        check("flush_never_valid", 256'(vcnt), 256'(0));

        // Asynchronous reset mid-immediate, then a clean fetch
        code_len = 16'd100; pc_i = 16'd8; pc_req = 1'b1; rd_cnt = 0; rd_base = 16'd8;
        @(posedge clk);
        @(negedge clk);
        pc_req = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_opcode",    256'(opcode),     256'(0));
        check("arst_code_data", code_data,        256'(0));
        check("arst_insn_pc",   256'(insn_pc),    256'(0));
        check("arst_insn_len",  256'(insn_len),   256'(0));
        check("arst_valid",     256'(insn_valid), 256'(0));
        check("arst_rd_en",     256'(mem_rd_en),  256'(0));
        check("arst_mem_addr",  256'(mem_addr),   256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_fetch(16'd4, 16'd10, lat);
        check("post_rst_latency", 256'(lat),      256'(3));
        check("post_rst_opcode",  256'(opcode),   256'(8'h60));
        check("post_rst_data",    code_data,      256'(8'hAB));
        check("post_rst_len",     256'(insn_len), 256'(2));
        check("post_rst_reads",   256'(rd_cnt),   256'(2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/code_fetch.md
Name: code_fetch

Overview:
- Upstream neighbour of the execution core.
- Takes a program counter and reads EVM bytecode from a byte-wide, 1-cycle-latency code memory.
- Emits one decoded instruction per handshake: the `opcode`, plus the PUSH immediate assembled into a 256-bit `code_data` word, right-aligned and big-endian.
- Bytes at or past `code_len` read as zero, per EVM semantics.

Parameters:
- ADDR_W, 16, width of pc, code memory address and code_len.
- DATA_W, 256, width of code_data (EVM word).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort of the current fetch (e.g. on exit)
- code_len  input  ADDR_W  number of valid code bytes; stable while not idle
- pc_req  input  1  request a fetch at pc_i
- pc_i  input  ADDR_W  address of the instruction to fetch
- pc_ready  output  1  high in IDLE; a request is accepted when pc_req && pc_ready
- mem_rd_en  output  1  code memory read strobe
- mem_addr  output  ADDR_W  code memory byte address
- mem_rdata  input  8  read data, valid the cycle after mem_rd_en
- insn_valid  output  1  instruction outputs valid
- insn_ready  input  1  consumer accepts the instruction
- opcode  output  8  fetched opcode
- code_data  output  DATA_W  PUSH immediate, zero-extended; 0 for non-PUSH opcodes
- insn_pc  output  ADDR_W  pc of this instruction
- insn_len  output  6  1 + immediate byte count (1..33), the amount to advance pc

Behaviour:

Reset (rst_n low, async):
- state=IDLE.
- pc_ready=1 after release.
- insn_valid=0, mem_rd_en=0, mem_addr=0, opcode=0, code_data=0, insn_pc=0, insn_len=0.
- Reset mid-fetch drops any in-flight memory data.

States: IDLE, OP_RSP, IMM, VALID.

IDLE:
- pc_ready=1.
- On pc_req: latch pc_i.
- If pc_i < code_len: drive mem_rd_en=1, mem_addr=pc_i (combinational from pc_i) that cycle.
- Otherwise issue no read and mark the opcode byte as zero.
- Next state OP_RSP.

OP_RSP:
- Capture opcode = mem_rdata, or 0x00 (STOP) if no read was issued.
- n = opcode-0x5F for 0x60..0x7F; otherwise n=0. PUSH0 (0x5F) gives n=0 and code_data=0.
- If n>0: issue a read of pc+1 (subject to the bound rule below), load the byte counter with n, go to IMM.
- Otherwise go to VALID.

IMM:
- Each cycle: shift code_data left by 8 and OR in the returned byte (zero if no read was issued for it).
- If more bytes remain, issue the read for the next address in the same cycle (one read per cycle, pipelined).
- After the nth byte is captured, go to VALID.

Bound rule:
- A byte at address a = pc+k is read only if the 17-bit sum pc+k < code_len.
- Addresses that wrap past 2^ADDR_W-1 are treated as out of range and read as zero.
- A one-bit pipeline tag per issued slot records read/zero.

VALID:
- insn_valid=1; opcode, code_data, insn_pc, insn_len are held stable until insn_ready.
- On insn_valid && insn_ready: next state IDLE, insn_valid drops the following cycle.
- No back-to-back overlap; the next pc_req is accepted from IDLE.

Latency (pc_req at cycle T, insn_ready tied high):
- Non-PUSH: insn_valid at T+2.
- PUSHn: insn_valid at T+n+2.
- Exactly 1+n memory reads when fully in range.

Busy handling:
- pc_req while pc_ready=0 is ignored, not queued.

flush:
- Highest priority after reset, in every state.
- Next state IDLE, insn_valid=0 next cycle, mem_rd_en=0 in the flush cycle.
- Any returning byte is discarded.

Arithmetic:
- insn_len = n+1.
- Immediate is big-endian: the first byte fetched ends in bits [8n-1:8n-8].
- Bits above 8n are zero; code_data is cleared when a new fetch is accepted.

Decomposition:
- Shared package eesic_pkg holds:
  - opcode constants OP_STOP=8'h00, OP_PUSH0=8'h5F, OP_PUSH1=8'h60, OP_PUSH32=8'h7F;
  - the fetch state enum;
  - the WORD_W=256 constant.
- One natural combinational sub-module, push_len_decode: opcode -> {is_push, n[5:0]}. It is reusable by the interpreter.
- All sequencing stays in code_fetch.

Test Plan:
1. Memory at 0 = 0x01 (ADD), code_len=10, pc_req pc_i=0 at T -> insn_valid at T+2, opcode=0x01, code_data=0, insn_len=1, insn_pc=0, one read.
2. Bytes 60 AB at addr 4 (PUSH1), pc_i=4 -> opcode=0x60, code_data=0xAB, insn_len=2, valid at T+3, reads at addresses 4 and 5.
3. PUSH32 at 0, bytes 1..32 = 0x01..0x20 -> code_data=0x0102...1F20, insn_len=33, valid at T+34, 33 consecutive reads.
4. code_len=3, bytes 62 11 22 (PUSH3 at 0) -> code_data=0x112200, only 3 reads issued; pc_i=3 -> opcode=0x00, no reads.
5. insn_ready held low 5 cycles after valid -> outputs stable, pc_ready=0, a pc_req issued meanwhile is ignored; the fetch completes on the ready pulse, then returns to IDLE.
6. flush mid-PUSH32 at byte 10 -> IDLE next cycle, insn_valid never rises. rst_n low during IMM -> all outputs zero asynchronously; a clean PUSH1 fetch succeeds after release.
